// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter sharing one RAM bus: valid/ready accept, fixed-latency access, done pulse.
// Define MEM_ARB_FIXED_PRIO_EN to give port 1 absolute priority; otherwise ties alternate round-robin.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_rw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    input  logic              req1_valid,
    input  logic              req1_rw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_sel,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    inout  wire  [DATA_W-1:0] bus_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(RAM_LAT - 1);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                bus_sel_q, bus_sel_d;
    logic                bus_rw_q, bus_rw_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                drive_q, drive_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                done0_q, done0_d;
    logic                done1_q, done1_d;
    logic                grant_s;
    logic                accept_s;

    // Grant selection among currently valid requesters
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant_s = 1'b1;
`else
            grant_s = ~last_grant_q;
`endif
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign req0_ready = (state_q == IDLE) && !grant_s && req0_valid;
    assign req1_ready = (state_q == IDLE) &&  grant_s && req1_valid;
    assign accept_s   = req0_ready || req1_ready;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        rw_d         = rw_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        bus_sel_d    = bus_sel_q;
        bus_rw_d     = bus_rw_q;
        bus_addr_d   = bus_addr_q;
        drive_d      = drive_q;
        rdata_d      = rdata_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    rw_d         = grant_s ? req1_rw : req0_rw;
                    wdata_d      = grant_s ? req1_wdata : req0_wdata;
                    cnt_d        = CNT_INIT;
                    bus_sel_d    = 1'b1;
                    bus_rw_d     = rw_d;
                    bus_addr_d   = grant_s ? req1_addr : req0_addr;
                    drive_d      = rw_d;
                    state_d      = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last held cycle: RAM data is valid on the bus right now
                    if (!rw_q) begin
                        rdata_d = bus_data;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    done0_d    = ~owner_q;
                    done1_d    = owner_q;
                    bus_sel_d  = 1'b0;
                    bus_rw_d   = 1'b0;
                    bus_addr_d = {ADDR_W{1'b0}};
                    drive_d    = 1'b0;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                bus_sel_d  = 1'b0;
                bus_rw_d   = 1'b0;
                bus_addr_d = {ADDR_W{1'b0}};
                drive_d    = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rw_q         <= 1'b0;
            wdata_q      <= {DATA_W{1'b0}};
            cnt_q        <= 4'd0;
            bus_sel_q    <= 1'b0;
            bus_rw_q     <= 1'b0;
            bus_addr_q   <= {ADDR_W{1'b0}};
            drive_q      <= 1'b0;
            rdata_q      <= {DATA_W{1'b0}};
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            rw_q         <= rw_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            bus_sel_q    <= bus_sel_d;
            bus_rw_q     <= bus_rw_d;
            bus_addr_q   <= bus_addr_d;
            drive_q      <= drive_d;
            rdata_q      <= rdata_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    assign bus_data  = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign bus_sel   = bus_sel_q;
    assign bus_rw    = bus_rw_q;
    assign bus_addr  = bus_addr_q;
    assign rdata     = rdata_q;
    assign req0_done = done0_q;
    assign req1_done = done1_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: RAM_LAT=2 main instance plus a RAM_LAT=1 instance.
// An undriven data bus is pulled to all ones so the released (high-Z) state is observable.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req0_rw = 1'b0, req1_valid = 1'b0, req1_rw = 1'b0;
    logic [31:0] req0_addr = 32'h0, req0_wdata = 32'h0, req1_addr = 32'h0, req1_wdata = 32'h0;
    logic        req0_ready, req0_done, req1_ready, req1_done, bus_sel, bus_rw;
    logic [31:0] rdata, bus_addr;
    wire  [31:0] bus_data;
    logic [31:0] ram_word = 32'h0;

    logic        l_valid = 1'b0;
    logic [31:0] l_addr = 32'h0;
    logic        l_ready0, l_done0, l_ready1, l_done1, l_sel, l_rw;
    logic [31:0] l_rdata, l_bus_addr;
    wire  [31:0] l_bus_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    localparam logic [31:0] PULLED = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    pullup (bus_data);
    pullup (l_bus_data);
    assign bus_data   = (bus_sel && !bus_rw) ? ram_word : 32'hzzzz_zzzz;
    assign l_bus_data = (l_sel && !l_rw) ? 32'hA5A5_A5A5 : 32'hzzzz_zzzz;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready), .req1_done(req1_done),
        .rdata(rdata), .bus_sel(bus_sel), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_data(bus_data)
    );

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(l_valid), .req0_rw(1'b0), .req0_addr(l_addr), .req0_wdata(32'h0),
        .req0_ready(l_ready0), .req0_done(l_done0),
        .req1_valid(1'b0), .req1_rw(1'b0), .req1_addr(32'h0), .req1_wdata(32'h0),
        .req1_ready(l_ready1), .req1_done(l_done1),
        .rdata(l_rdata), .bus_sel(l_sel), .bus_rw(l_rw), .bus_addr(l_bus_addr), .bus_data(l_bus_data)
    );

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || req0_done !== 1'b0 || req1_done !== 1'b0) begin
            errors++; $display("FAIL reset_hs got r0=%b r1=%b d0=%b d1=%b want 0", req0_ready, req1_ready, req0_done, req1_done);
        end
        checks++;
        if (bus_sel !== 1'b0 || bus_rw !== 1'b0 || bus_addr !== 32'h0 || rdata !== 32'h0) begin
            errors++; $display("FAIL reset_bus got sel=%b rw=%b addr=%h rdata=%h want 0", bus_sel, bus_rw, bus_addr, rdata);
        end
        checks++;
        if (bus_data !== PULLED || l_sel !== 1'b0 || l_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_z got data=%h lsel=%b lrdata=%h want released", bus_data, l_sel, l_rdata);
        end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        exp_t e;
        ram_word = 32'hDEAD_BEEF;
        @(posedge clk); #1; req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 32'h10;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL rd_ready got %b/%b want 1/0", req0_ready, req1_ready);
        end
        if (req0_ready === 1'b1) sb_q.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
        @(posedge clk); #1; req0_valid = 1'b0; req0_addr = 32'hFFFF_0000;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus_sel !== (c <= 2) || bus_addr !== ((c <= 2) ? 32'h10 : 32'h0) || bus_rw !== 1'b0
                || req0_done !== (c == 3) || req1_done !== 1'b0) begin
                errors++; $display("FAIL rd_cyc%0d got sel=%b addr=%h rw=%b d0=%b d1=%b", c, bus_sel, bus_addr, bus_rw, req0_done, req1_done);
            end
            if (req0_done === 1'b1 || req1_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL rd_sb got unexpected done want none");
                end else begin
                    e = sb_q.pop_front();
                    if (req1_done !== e.port || rdata !== e.data) begin
                        errors++; $display("FAIL rd_data got port=%b rdata=%h want port=%b rdata=%h", req1_done, rdata, e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_write_p1;
        exp_t e;
        @(posedge clk); #1; req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || bus_data !== PULLED) begin
            errors++; $display("FAIL wr_ready got ready=%b data=%h want 1/%h", req1_ready, bus_data, PULLED);
        end
        if (req1_ready === 1'b1) sb_q.push_back('{port: 1'b1, data: 32'hDEAD_BEEF});
        @(posedge clk); #1; req1_valid = 1'b0; req1_wdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus_rw !== (c <= 2) || bus_data !== ((c <= 2) ? 32'h1234_5678 : PULLED)
                || bus_addr !== ((c <= 2) ? 32'h20 : 32'h0) || req1_done !== (c == 3) || req0_done !== 1'b0) begin
                errors++; $display("FAIL wr_cyc%0d got rw=%b data=%h addr=%h d1=%b d0=%b", c, bus_rw, bus_data, bus_addr, req1_done, req0_done);
            end
            if (req0_done === 1'b1 || req1_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL wr_sb got unexpected done want none");
                end else begin
                    e = sb_q.pop_front();
                    if (req1_done !== e.port || rdata !== e.data) begin
                        errors++; $display("FAIL wr_done got port=%b rdata=%h want port=%b rdata=%h", req1_done, rdata, e.port, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_round_robin;
        exp_t       e;
        logic [2:0] g_seq;
        logic       g;
`ifdef MEM_ARB_FIXED_PRIO_EN
        g_seq = 3'b111;
`else
        g_seq = 3'b010;
`endif
        ram_word = 32'hCAFE_0001;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 32'h40;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 32'h80;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            g = g_seq[c / 4];
            checks++;
            if (req0_ready !== ((c % 4 == 0) && !g) || req1_ready !== ((c % 4 == 0) && g)) begin
                errors++; $display("FAIL rr_ready c%0d got %b/%b want grant %b", c, req0_ready, req1_ready, g);
            end
            if (req0_ready === 1'b1 || req1_ready === 1'b1) sb_q.push_back('{port: g, data: 32'hCAFE_0001});
            if (c % 4 == 1) begin
                checks++;
                if (bus_addr !== (g ? 32'h80 : 32'h40)) begin
                    errors++; $display("FAIL rr_addr c%0d got %h want %h", c, bus_addr, g ? 32'h80 : 32'h40);
                end
            end
            if (c % 4 == 3) begin
                checks++;
                if (sb_q.size() == 0 || req0_done !== !g || req1_done !== g) begin
                    errors++; $display("FAIL rr_done c%0d got %b/%b want grant %b", c, req0_done, req1_done, g);
                end else begin
                    e = sb_q.pop_front();
                    if (req1_done !== e.port || rdata !== e.data) begin
                        errors++; $display("FAIL rr_data got port=%b rdata=%h want port=%b rdata=%h", req1_done, rdata, e.port, e.data);
                    end
                end
            end
        end
        @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        ram_word = 32'h1111_2222;
        @(posedge clk); #1; req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 32'h50;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== (c == 0 || c == 4) || req1_ready !== 1'b0 || req0_done !== (c == 3 || c == 7)) begin
                errors++; $display("FAIL b2b c%0d got r0=%b r1=%b d0=%b", c, req0_ready, req1_ready, req0_done);
            end
            if (req0_ready === 1'b1) sb_q.push_back('{port: 1'b0, data: 32'h1111_2222});
            if (req0_done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++; $display("FAIL b2b_sb got unexpected done want none");
                end else begin
                    e = sb_q.pop_front();
                    if (rdata !== e.data) begin
                        errors++; $display("FAIL b2b_data got %h want %h", rdata, e.data);
                    end
                end
            end
        end
        @(posedge clk); #1; req0_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        logic win;
`ifdef MEM_ARB_FIXED_PRIO_EN
        win = 1'b1;
`else
        win = 1'b0;
`endif
        @(posedge clk); #1; req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = 32'h30; req0_wdata = 32'h55AA_55AA;
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_sel !== 1'b1 || bus_data !== 32'h55AA_55AA) begin
            errors++; $display("FAIL rm_access got sel=%b data=%h want 1/55aa55aa", bus_sel, bus_data);
        end
        #1; rst_n = 1'b0;
        #1;
        checks++;
        if (bus_sel !== 1'b0 || bus_data !== PULLED || bus_addr !== 32'h0) begin
            errors++; $display("FAIL rm_release got sel=%b data=%h addr=%h want released", bus_sel, bus_data, bus_addr);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req0_done !== 1'b0 || req1_done !== 1'b0) begin
                errors++; $display("FAIL rm_nodone got %b/%b want 0/0", req0_done, req1_done);
            end
        end
        ram_word = 32'h0F0F_0F0F;
        @(posedge clk); #1; rst_n = 1'b1;
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = 32'h60;
        req1_valid = 1'b1; req1_rw = 1'b0; req1_addr = 32'h70;
        @(negedge clk);
        checks++;
        if (req0_ready !== !win || req1_ready !== win) begin
            errors++; $display("FAIL rm_tie got %b/%b want winner %b", req0_ready, req1_ready, win);
        end
        if (req0_ready === 1'b1 || req1_ready === 1'b1) sb_q.push_back('{port: win, data: 32'h0F0F_0F0F});
        @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (sb_q.size() == 0 || req0_done !== !win || req1_done !== win) begin
                    errors++; $display("FAIL rm_done got %b/%b want winner %b", req0_done, req1_done, win);
                end else begin
                    e = sb_q.pop_front();
                    if (rdata !== e.data || req1_done !== e.port) begin
                        errors++; $display("FAIL rm_data got %h want %h", rdata, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_lat1;
        exp_t e;
        @(posedge clk); #1; l_valid = 1'b1; l_addr = 32'h4;
        @(negedge clk);
        checks++;
        if (l_ready0 !== 1'b1 || l_ready1 !== 1'b0) begin
            errors++; $display("FAIL l1_ready got %b/%b want 1/0", l_ready0, l_ready1);
        end
        if (l_ready0 === 1'b1) sb_q.push_back('{port: 1'b0, data: 32'hA5A5_A5A5});
        @(posedge clk); #1; l_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (l_sel !== 1'b1 || l_bus_addr !== 32'h4 || l_done0 !== 1'b0) begin
            errors++; $display("FAIL l1_access got sel=%b addr=%h done=%b want 1/4/0", l_sel, l_bus_addr, l_done0);
        end
        @(negedge clk);
        checks++;
        if (l_sel !== 1'b0 || l_done0 !== 1'b1 || l_done1 !== 1'b0 || sb_q.size() == 0) begin
            errors++; $display("FAIL l1_done got sel=%b d0=%b d1=%b want 0/1/0", l_sel, l_done0, l_done1);
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (l_rdata !== e.data) begin
                errors++; $display("FAIL l1_data got %h want %h", l_rdata, e.data);
            end
        end
        @(negedge clk);
        checks++;
        if (l_done0 !== 1'b0 || l_ready0 !== 1'b0) begin
            errors++; $display("FAIL l1_after got done=%b ready=%b want 0/0", l_done0, l_ready0);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_p1();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_lat1();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_empty got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
